// File: rtl/pwm_tx_pkg.sv
// pwm_tx_pkg: shared constants, state encoding and the saturation helper
// for the PWM transmitter and its optional slew limiter (PWM_TX_SLEW_EN).
package pwm_tx_pkg;

  localparam int DUTY_W_DEF   = 10;
  localparam int PERIOD       = 1 << DUTY_W_DEF;
  localparam int DUTY_SAT_MIN = 0;
  localparam int DUTY_SAT_MAX = PERIOD - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Clamp a signed intermediate duty into [DUTY_SAT_MIN, max_value].
  function automatic int sat_duty(input int value, input int max_value);
    if (value < DUTY_SAT_MIN) return DUTY_SAT_MIN;
    if (value > max_value) return max_value;
    return value;
  endfunction

endpackage

// File: rtl/pwm_tx_slew.sv
// pwm_tx_slew: combinational next-duty step toward a target, limited to
// SLEW_STEP per period and saturated to the duty range. Only instantiated
// by pwm_transmitter when PWM_TX_SLEW_EN is defined.
module pwm_tx_slew
  import pwm_tx_pkg::*;
#(
  parameter int DUTY_W    = DUTY_W_DEF,
  parameter int SLEW_STEP = 16
) (
  input  logic [DUTY_W-1:0] active,
  input  logic [DUTY_W-1:0] target,
  output logic [DUTY_W-1:0] next_duty
);

  localparam int MAX_V = (1 << DUTY_W) - 1;

  int diff;
  int stepped;

  // Move by at most SLEW_STEP; land exactly on the target once within reach.
  always_comb begin
    diff    = int'(target) - int'(active);
    stepped = int'(target);
    if (diff > SLEW_STEP) begin
      stepped = int'(active) + SLEW_STEP;
    end else if (diff < -SLEW_STEP) begin
      stepped = int'(active) - SLEW_STEP;
    end
    next_duty = DUTY_W'(sat_duty(stepped, MAX_V));
  end

endmodule

// File: rtl/pwm_transmitter.sv
// pwm_transmitter: fixed-period PWM generator (period 2**DUTY_W cycles).
// Duty words are buffered in a one-entry pending slot and applied only at
// period boundaries, so pulses are never truncated. Optional build macro
// PWM_TX_SLEW_EN limits the per-period duty change to SLEW_STEP.
module pwm_transmitter
  import pwm_tx_pkg::*;
#(
  parameter int DUTY_W    = DUTY_W_DEF,
  parameter int SLEW_STEP = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DUTY_W-1:0] duty,
  input  logic              duty_valid,
  output logic              duty_ready,
  output logic              pwm,
  output logic              period_start,
  output logic [DUTY_W-1:0] active_duty,
  output logic              busy
);

  localparam logic [DUTY_W-1:0] CNT_LAST = '1;

  state_t            state_reg, state_next;
  logic [DUTY_W-1:0] cnt_reg, cnt_next;
  logic [DUTY_W-1:0] pending_reg;
  logic [DUTY_W-1:0] active_reg, active_next;
  logic [DUTY_W-1:0] applied_duty;
  logic              full_reg, full_next;
  logic              pwm_reg, period_start_reg, busy_reg;
  logic              accept, boundary, apply_done;

  assign accept   = duty_valid && !full_reg;
  // A new period begins only in the cycle where RUN sees cnt=0.
  assign boundary = (state_reg == RUN) && (cnt_reg == '0);

`ifdef PWM_TX_SLEW_EN
  pwm_tx_slew #(
    .DUTY_W    (DUTY_W),
    .SLEW_STEP (SLEW_STEP)
  ) u_slew (
    .active    (active_reg),
    .target    (pending_reg),
    .next_duty (applied_duty)
  );
`else
  assign applied_duty = pending_reg;
  // SLEW_STEP has no effect without slew limiting.
  if (SLEW_STEP < 0) begin : g_slew_step_ignored
  end
`endif

  // The slot frees only once the active duty has reached the pending word.
  assign apply_done  = boundary && full_reg && (applied_duty == pending_reg);
  assign active_next = (boundary && full_reg) ? applied_duty : active_reg;

  // Next state and period counter; the counter only runs while busy.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 1'b1;
    unique case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (enable) state_next = RUN;
      end
      RUN: begin
        // Dropping enable on the last cycle already completes the period.
        if (!enable) state_next = (cnt_reg == CNT_LAST) ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (enable) state_next = RUN;
        else if (cnt_reg == CNT_LAST) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Pending-slot occupancy: set by a handshake, cleared by a completed apply.
  always_comb begin
    full_next = full_reg;
    if (apply_done) full_next = 1'b0;
    if (accept) full_next = 1'b1;
  end

  // State, counter and pending/active duty registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      full_reg    <= 1'b0;
      pending_reg <= '0;
      active_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      full_reg   <= full_next;
      active_reg <= active_next;
      if (accept) pending_reg <= duty;
    end
  end

  // Registered outputs, all aligned one cycle after the counter value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_reg          <= 1'b0;
      period_start_reg <= 1'b0;
      busy_reg         <= 1'b0;
    end else begin
      pwm_reg          <= (state_reg != IDLE) && (cnt_reg < active_next);
      period_start_reg <= boundary;
      busy_reg         <= (state_reg != IDLE);
    end
  end

  assign duty_ready   = !full_reg;
  assign pwm          = pwm_reg;
  assign period_start = period_start_reg;
  assign active_duty  = active_reg;
  assign busy         = busy_reg;

endmodule
